// File: rtl/input_debouncer_pkg.sv
`default_nettype none
// input_debouncer_pkg: shared widths, default timing parameters and counter sizing.
package input_debouncer_pkg;

    localparam int DATA_WIDTH              = 8;
    localparam int DEFAULT_SYNC_STAGES     = 2;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000;

    // A 1-bit counter is still needed when DEBOUNCE_CYCLES is 2.
    function automatic int cnt_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage : input_debouncer_pkg
`default_nettype wire

// File: rtl/input_debouncer_bit.sv
`default_nettype none
// debounce_bit: synchroniser chain, per-bit mismatch counter and debounced output flop.
module debounce_bit
    import input_debouncer_pkg::*;
#(
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic data_o
);

    localparam int                CW      = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]     CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   data_q, data_d;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    always_comb begin
        cnt_d  = cnt_q;
        data_d = data_q;
        if (synced == data_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            data_d = synced;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
            data_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
            cnt_q  <= cnt_d;
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule : debounce_bit
`default_nettype wire

// File: rtl/input_debouncer.sv
`default_nettype none
// input_debouncer: eight independent debounced bits plus a registered change pulse and mask.
module input_debouncer
    import input_debouncer_pkg::*;
#(
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] raw,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  changed,
    output logic [DATA_WIDTH-1:0] changed_mask
);

    logic [DATA_WIDTH-1:0] data_w;
    logic [DATA_WIDTH-1:0] data_prev_q;
    logic [DATA_WIDTH-1:0] mask_d, mask_q;
    logic                  changed_q;

    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
        debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_bit (
            .clk    (clk),
            .rst_n  (rst_n),
            .raw_i  (raw[i]),
            .data_o (data_w[i])
        );
    end

    // data_prev_q lags data by one edge, so the mask lands one cycle after the flip.
    assign mask_d = data_w ^ data_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_prev_q <= '0;
            mask_q      <= '0;
            changed_q   <= 1'b0;
        end else begin
            data_prev_q <= data_w;
            mask_q      <= mask_d;
            changed_q   <= |mask_d;
        end
    end

    assign data         = data_w;
    assign changed      = changed_q;
    assign changed_mask = mask_q;

endmodule : input_debouncer
`default_nettype wire

// File: tb/tb_input_debouncer.sv
`default_nettype none
// tb_input_debouncer: directed scenarios plus random stimulus against a window-based reference model.
module tb_input_debouncer;

    localparam int SYNC = 2;
    localparam int DEB  = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] raw;
    logic [7:0] data;
    logic       changed;
    logic [7:0] changed_mask;

    int n_vec = 0;
    int n_err = 0;

    input_debouncer #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .raw          (raw),
        .data         (data),
        .changed      (changed),
        .changed_mask (changed_mask)
    );

    always #5 clk = ~clk;

    // Reference: a bit flips once its last DEB synchronised samples all disagree with it.
    logic [7:0] m_pipe [SYNC];
    logic [7:0] m_win [$];
    logic [7:0] m_data, m_mask, m_flip_prev;
    logic       m_chg;

    task automatic model_reset();
        for (int j = 0; j < SYNC; j++) m_pipe[j] = 8'h00;
        m_win.delete();
        m_data      = 8'h00;
        m_mask      = 8'h00;
        m_flip_prev = 8'h00;
        m_chg       = 1'b0;
    endtask

    task automatic model_edge(input logic [7:0] r);
        logic [7:0] s;
        logic [7:0] flip;
        s = m_pipe[SYNC-1];
        for (int j = SYNC - 1; j > 0; j--) m_pipe[j] = m_pipe[j-1];
        m_pipe[0] = r;
        m_win.push_back(s);
        if (m_win.size() > DEB) void'(m_win.pop_front());
        flip = 8'h00;
        if (m_win.size() == DEB) begin
            for (int b = 0; b < 8; b++) begin
                flip[b] = 1'b1;
                for (int k = 0; k < DEB; k++)
                    if (m_win[k][b] == m_data[b]) flip[b] = 1'b0;
            end
        end
        m_mask      = m_flip_prev;
        m_chg       = |m_flip_prev;
        m_flip_prev = flip;
        m_data      = m_data ^ flip;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(raw);
        #1;
        check_eq("data", 32'(data), 32'(m_data));
        check_eq("changed", 32'(changed), 32'(m_chg));
        check_eq("mask", 32'(changed_mask), 32'(m_mask));
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("rst_data", 32'(data), 32'h00);
        check_eq("rst_changed", 32'(changed), 32'h0);
        check_eq("rst_mask", 32'(changed_mask), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int seen_chg;
        int r;
        rst_n = 1'b0;
        raw   = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("init_data", 32'(data), 32'h00);
        check_eq("init_changed", 32'(changed), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle hold after reset.
        seen_chg = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (changed) seen_chg = 1;
        end
        check_eq("idle_data", 32'(data), 32'h00);
        check_eq("idle_chg_seen", 32'(seen_chg), 32'h0);

        // Single bit, clean edge: data at edge 6, pulse at edge 7 only.
        raw = 8'h80;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 5) check_eq("b7_early", 32'(data), 32'h00);
            if (k == 6) check_eq("b7_data", 32'(data), 32'h80);
            if (k == 6) check_eq("b7_nochg6", 32'(changed), 32'h0);
            if (k == 7) check_eq("b7_chg", 32'(changed), 32'h1);
            if (k == 7) check_eq("b7_mask", 32'(changed_mask), 32'h80);
            if (k == 8) check_eq("b7_nochg8", 32'(changed), 32'h0);
        end
        pulse_reset();

        // Bounce on bit 3.
        raw = 8'h08; step();
        raw = 8'h00; step();
        raw = 8'h08;
        seen_chg = 0;
        for (int k = 1; k <= 7; k++) begin
            step();
            if (k <= 6 && changed) seen_chg = 1;
            if (k == 5) check_eq("b3_early", 32'(data), 32'h00);
            if (k == 6) check_eq("b3_data", 32'(data), 32'h08);
            if (k == 7) check_eq("b3_mask", 32'(changed_mask), 32'h08);
        end
        check_eq("b3_bounce_chg", 32'(seen_chg), 32'h0);
        pulse_reset();

        // Two bits together -> one pulse.
        raw = 8'h21;
        repeat (6) step();
        check_eq("dual_data", 32'(data), 32'h21);
        step();
        check_eq("dual_chg", 32'(changed), 32'h1);
        check_eq("dual_mask", 32'(changed_mask), 32'h21);
        step();
        check_eq("dual_chg_end", 32'(changed), 32'h0);
        pulse_reset();

        // Staggered bits -> back-to-back pulses.
        raw = 8'h01; step();
        raw = 8'h03;
        for (int k = 2; k <= 9; k++) begin
            step();
            if (k == 7) check_eq("stag_mask1", 32'(changed_mask), 32'h01);
            if (k == 7) check_eq("stag_chg1", 32'(changed), 32'h1);
            if (k == 8) check_eq("stag_mask2", 32'(changed_mask), 32'h02);
            if (k == 8) check_eq("stag_chg2", 32'(changed), 32'h1);
            if (k == 9) check_eq("stag_chg3", 32'(changed), 32'h0);
        end
        pulse_reset();

        // Reset mid-count discards partial progress.
        raw = 8'hFF;
        repeat (3) step();
        pulse_reset();
        for (int k = 1; k <= 7; k++) begin
            step();
            if (k == 1) check_eq("rel_nochg", 32'(changed), 32'h0);
            if (k == 5) check_eq("rel_early", 32'(data), 32'h00);
            if (k == 6) check_eq("rel_data", 32'(data), 32'hFF);
            if (k == 7) check_eq("rel_mask", 32'(changed_mask), 32'hFF);
        end

        // Random stimulus with occasional glitches, bursts and resets.
        for (int it = 0; it < 800; it++) begin
            r = int'($urandom_range(0, 99));
            if (r < 20)       raw = raw ^ (8'h01 << $urandom_range(0, 7));
            else if (r < 24)  raw = 8'($urandom);
            else if (r == 24) pulse_reset();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_input_debouncer
`default_nettype wire
